// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone burst-read master feeding the stream writer FIFO: a burst is issued only
// once the FIFO has room for all of it, so acknowledged beats pass straight through.
module wb_stream_writer_ctrl #(
  parameter int WB_AW       = 32,
  parameter int WB_DW       = 32,
  parameter int FIFO_AW     = 0,
  parameter int MAX_BURST_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [WB_AW-1:0]       wbm_adr_o,
  output logic [WB_DW/8-1:0]     wbm_sel_o,
  output logic                   wbm_we_o,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic [2:0]             wbm_cti_o,
  output logic [1:0]             wbm_bte_o,
  input  logic [WB_DW-1:0]       wbm_dat_i,
  input  logic                   wbm_ack_i,
  input  logic                   wbm_err_i,
  output logic [WB_DW-1:0]       fifo_data_o,
  output logic                   fifo_valid_o,
  input  logic                   fifo_ready_i,
  input  logic [FIFO_AW:0]       fifo_cnt_i,
  input  logic                   enable_i,
  input  logic [WB_AW-1:0]       start_adr_i,
  input  logic [WB_AW-1:0]       buf_size_i,
  input  logic [MAX_BURST_W-1:0] burst_size_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int BEAT_BYTES = WB_DW / 8;
  // Wide enough to hold both a burst length and the FIFO capacity without truncation
  localparam int CMP_W = ((MAX_BURST_W > FIFO_AW + 1) ? MAX_BURST_W : FIFO_AW + 1) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST} state_t;

  state_t                 state, state_nx;
  logic [WB_AW-1:0]       adr;
  logic [WB_AW-1:0]       remaining;
  logic [MAX_BURST_W-1:0] bsize;
  logic [MAX_BURST_W-1:0] beat_cnt;
  logic                   done, err;

  logic                   start, load_burst, beat, done_nx, err_set;
  logic [MAX_BURST_W-1:0] rem_sat, blen;
  logic [CMP_W-1:0]       cap, cnt_x, space;
  logic                   fits;

  // Ready is guaranteed by the space reservation, so it carries no control meaning here
  logic unused_ready;
  assign unused_ready = fifo_ready_i;

  function automatic logic [MAX_BURST_W-1:0] sat_rem(input logic [WB_AW-1:0] r);
    if ((r >> MAX_BURST_W) != '0) return '1;
    return MAX_BURST_W'(r);
  endfunction

  always_comb begin
    rem_sat = sat_rem(remaining);
    blen    = (bsize < rem_sat) ? bsize : rem_sat;
    cap     = CMP_W'(1) << FIFO_AW;
    cnt_x   = CMP_W'(fifo_cnt_i);
    space   = (cnt_x >= cap) ? '0 : cap - cnt_x;
    fits    = space >= CMP_W'(blen);
  end

  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    load_burst = 1'b0;
    beat       = 1'b0;
    done_nx    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          start = 1'b1;
          if (buf_size_i == '0) done_nx = 1'b1;
          else                  state_nx = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (remaining == '0) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (fits) begin
          load_burst = 1'b1;
          state_nx   = BURST;
        end
      end
      BURST: begin
        if (wbm_err_i) begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end else if (wbm_ack_i) begin
          beat = 1'b1;
          if (beat_cnt == MAX_BURST_W'(1)) state_nx = WAIT_SPACE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      adr       <= '0;
      remaining <= '0;
      bsize     <= '0;
      beat_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (start) begin
        adr       <= start_adr_i;
        remaining <= buf_size_i;
        bsize     <= (burst_size_i == '0) ? MAX_BURST_W'(1) : burst_size_i;
        err       <= 1'b0;
      end
      if (err_set) err <= 1'b1;
      if (load_burst) beat_cnt <= blen;
      if (beat) begin
        adr       <= adr + WB_AW'(BEAT_BYTES);
        remaining <= remaining - WB_AW'(1);
        beat_cnt  <= beat_cnt - MAX_BURST_W'(1);
      end
    end
  end

  // Bus and stream outputs; ack data is forwarded combinationally
  always_comb begin
    wbm_cyc_o    = (state == BURST);
    wbm_stb_o    = wbm_cyc_o;
    wbm_we_o     = 1'b0;
    wbm_bte_o    = 2'b00;
    wbm_adr_o    = adr;
    wbm_sel_o    = {(WB_DW/8){wbm_cyc_o}};
    wbm_cti_o    = 3'b000;
    if (wbm_cyc_o) wbm_cti_o = (beat_cnt == MAX_BURST_W'(1)) ? 3'b111 : 3'b010;
    fifo_valid_o = wbm_cyc_o && wbm_ack_i && !wbm_err_i;
    fifo_data_o  = wbm_dat_i;
    busy_o       = (state != IDLE);
    done_o       = done;
    err_o        = err;
  end

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Randomized scoreboard bench for wb_stream_writer_ctrl with a Wishbone slave and FIFO model.
module tb_wb_stream_writer_ctrl;
  localparam int AW = 32, DW = 32, FAW = 4, MBW = 8, CAP = 16;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0]   wbm_adr_o;
  logic [DW/8-1:0] wbm_sel_o;
  logic            wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]      wbm_cti_o;
  logic [1:0]      wbm_bte_o;
  logic [DW-1:0]   wbm_dat_i;
  logic            wbm_ack_i, wbm_err_i;
  logic [DW-1:0]   fifo_data_o;
  logic            fifo_valid_o, fifo_ready_i;
  logic [FAW:0]    fifo_cnt_i;
  logic            enable_i;
  logic [AW-1:0]   start_adr_i, buf_size_i;
  logic [MBW-1:0]  burst_size_i;
  logic            busy_o, done_o, err_o;

  always #5 clk = ~clk;

  wb_stream_writer_ctrl #(.WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW), .MAX_BURST_W(MBW)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .fifo_data_o(fifo_data_o), .fifo_valid_o(fifo_valid_o),
    .fifo_ready_i(fifo_ready_i), .fifo_cnt_i(fifo_cnt_i), .enable_i(enable_i),
    .start_adr_i(start_adr_i), .buf_size_i(buf_size_i), .burst_size_i(burst_size_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed { logic [31:0] adr; logic [2:0] cti; } beat_t;
  beat_t       exp_bus[$];
  logic [31:0] exp_dat[$];
  beat_t       mb;
  logic [31:0] md;

  int total = 0, bad = 0;
  int done_cnt = 0, cyc_cnt = 0;
  int beat_total = 0, err_at = -1, wait_pct = 0;
  int fcnt = 0, forced = 0;
  bit force_cnt = 0, drain_en = 1, fw;

  assign fifo_ready_i = (fcnt < CAP);
  assign fifo_cnt_i   = force_cnt ? 5'(forced) : 5'(fcnt);

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wishbone slave: random wait states, optional error on a chosen beat
  initial begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
      if (wbm_cyc_o && wbm_stb_o && !rst && ($urandom_range(99) >= wait_pct)) begin
        if (err_at >= 0 && beat_total == err_at) begin
          wbm_err_i = 1'b1;
          err_at = -1;
        end else begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = mem(wbm_adr_o);
          beat_total++;
        end
      end
    end
  end

  // FIFO occupancy model with random draining
  initial forever begin
    @(negedge clk);
    fw = fifo_valid_o && fifo_ready_i;
    @(posedge clk); #1;
    if (fw) fcnt++;
    if (drain_en && fcnt > 0 && $urandom_range(1) == 1) fcnt--;
  end

  // Monitor: pops expectations whenever the DUT presents a beat or a FIFO write
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (done_o) begin
        done_cnt++;
        check("busy_low_at_done", 32'(busy_o), 32'(0));
      end
      if (wbm_cyc_o) begin
        cyc_cnt++;
        if (wbm_ack_i || wbm_err_i) begin
          check("stb_eq_cyc", 32'(wbm_stb_o), 32'(1));
          check("sel_all", 32'(wbm_sel_o), 32'hF);
          check("we_zero", 32'(wbm_we_o), 32'(0));
          if (exp_bus.size() == 0) begin
            total++; bad++;
            $display("FAIL bus_beat: unexpected beat at adr %0h, none required", wbm_adr_o);
          end else begin
            mb = exp_bus.pop_front();
            check("beat_adr", wbm_adr_o, mb.adr);
            check("beat_cti", 32'(wbm_cti_o), 32'(mb.cti));
          end
        end
      end
      if (fifo_valid_o) begin
        check("ready_on_valid", 32'(fifo_ready_i), 32'(1));
        check("valid_only_on_ack", 32'(wbm_ack_i), 32'(1));
        if (exp_dat.size() == 0) begin
          total++; bad++;
          $display("FAIL fifo_write: unexpected write %0h, none required", fifo_data_o);
        end else begin
          md = exp_dat.pop_front();
          check("fifo_data", fifo_data_o, md);
        end
      end
    end
  end

  // Reference: split the buffer into bursts of min(bsize, remaining) words
  task automatic prepare(input logic [31:0] sa, input int n, input int bs, input int err_off);
    int b, off, len, g;
    beat_t eb;
    b = (bs == 0) ? 1 : bs;
    off = 0;
    while (off < n) begin
      len = (n - off < b) ? n - off : b;
      for (int k = 0; k < len; k++) begin
        g = off + k;
        eb.adr = sa + 32'(4 * g);
        eb.cti = (k == len - 1) ? 3'b111 : 3'b010;
        if (err_off < 0 || g <= err_off) exp_bus.push_back(eb);
        if (err_off < 0 || g < err_off)  exp_dat.push_back(mem(eb.adr));
      end
      off += len;
    end
    if (err_off >= 0) err_at = beat_total + err_off;
  endtask

  task automatic pulse_start(input logic [31:0] sa, input int n, input int bs);
    @(posedge clk); #1;
    start_adr_i = sa; buf_size_i = 32'(n); burst_size_i = 8'(bs); enable_i = 1'b1;
    @(posedge clk); #1;
    enable_i = 1'b0;
    check("err_cleared_on_start", 32'(err_o), 32'(0));
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy_o && t < 5000) begin @(posedge clk); #1; t++; end
    if (busy_o) begin
      total++; bad++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, t);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic finish_chk(input int d0, input int c0, input int n, input int exp_done,
                            input int exp_err);
    check("bus_queue_empty", 32'(exp_bus.size()), 32'(0));
    check("data_queue_empty", 32'(exp_dat.size()), 32'(0));
    check("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
    check("err_o", 32'(err_o), 32'(exp_err));
    if (n == 0) check("no_bus_cycle", 32'(cyc_cnt - c0), 32'(0));
    exp_bus.delete(); exp_dat.delete(); err_at = -1;
  endtask

  task automatic run(input logic [31:0] sa, input int n, input int bs, input int err_off,
                     input bit chk_lat);
    int d0, c0;
    prepare(sa, n, bs, err_off);
    d0 = done_cnt; c0 = cyc_cnt;
    pulse_start(sa, n, bs);
    if (chk_lat) begin
      check("lat_busy", 32'(busy_o), 32'(1));
      check("lat_cyc_early", 32'(wbm_cyc_o), 32'(0));
      @(posedge clk); #1;
      check("lat_cyc_on", 32'(wbm_cyc_o), 32'(1));
    end
    wait_idle("run");
    finish_chk(d0, c0, n, (err_off < 0) ? 1 : 0, (err_off >= 0) ? 1 : 0);
  endtask

  task automatic drain_fifo();
    int t;
    t = 0;
    while (fcnt != 0 && t < 500) begin @(posedge clk); #1; t++; end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_adr"}, wbm_adr_o, 32'(0));
    check({tag, "_sel"}, 32'(wbm_sel_o), 32'(0));
    check({tag, "_cyc"}, 32'(wbm_cyc_o), 32'(0));
    check({tag, "_stb"}, 32'(wbm_stb_o), 32'(0));
    check({tag, "_we"}, 32'(wbm_we_o), 32'(0));
    check({tag, "_cti"}, 32'(wbm_cti_o), 32'(0));
    check({tag, "_bte"}, 32'(wbm_bte_o), 32'(0));
    check({tag, "_valid"}, 32'(fifo_valid_o), 32'(0));
    check({tag, "_busy"}, 32'(busy_o), 32'(0));
    check({tag, "_done"}, 32'(done_o), 32'(0));
    check({tag, "_err"}, 32'(err_o), 32'(0));
  endtask

  initial begin
    int d0, c0, n, bs, eo;
    logic [31:0] sa;
    rst = 1'b1; enable_i = 1'b0; start_adr_i = '0; buf_size_i = '0; burst_size_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;

    // Two full bursts, zero-wait slave, first-cycle latency
    wait_pct = 0;
    run(32'h100, 8, 4, -1, 1'b1);
    check("final_adr_8", wbm_adr_o, 32'h120);

    // Bursts of 4, 4, 2
    drain_fifo();
    run(32'h100, 10, 4, -1, 1'b0);
    check("final_adr_10", wbm_adr_o, 32'h128);

    // Space reservation: 14 and 13 block a burst of 4, 12 releases it
    force_cnt = 1'b1; forced = 14;
    prepare(32'h200, 4, 4, -1);
    d0 = done_cnt; c0 = cyc_cnt;
    pulse_start(32'h200, 4, 4);
    repeat (8) @(posedge clk);
    #1;
    check("ws14_no_cyc", 32'(cyc_cnt - c0), 32'(0));
    check("ws14_busy", 32'(busy_o), 32'(1));
    forced = 13;
    repeat (4) @(posedge clk);
    #1;
    check("ws13_no_cyc", 32'(cyc_cnt - c0), 32'(0));
    forced = 12;
    @(posedge clk); #1;
    check("ws12_cyc_on", 32'(wbm_cyc_o), 32'(1));
    wait_idle("ws");
    finish_chk(d0, c0, 4, 1, 0);
    force_cnt = 1'b0;

    // Error on the third beat, then a clean start clears err_o
    drain_fifo();
    run(32'h100, 8, 4, 2, 1'b0);
    check("err_idle", 32'(busy_o), 32'(0));
    run(32'h500, 4, 2, -1, 1'b0);

    // Reset in the middle of a burst
    drain_fifo();
    prepare(32'h300, 8, 4, -1);
    pulse_start(32'h300, 8, 4);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_cyc", 32'(wbm_cyc_o), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("midrst");
    rst = 1'b0;
    exp_bus.delete(); exp_dat.delete();
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(busy_o), 32'(0));

    // Empty buffer, address wrap, burst size 0
    run(32'h400, 0, 4, -1, 1'b0);
    drain_fifo();
    run(32'hFFFF_FFF8, 4, 4, -1, 1'b0);
    check("wrap_adr", wbm_adr_o, 32'h8);
    run(32'h600, 3, 0, -1, 1'b0);

    // Randomized transfers with wait states and occasional errors
    for (int i = 0; i < 10; i++) begin
      sa = $urandom & 32'hFFFF_FFFC;
      n  = $urandom_range(1, 20);
      bs = $urandom_range(0, 6);
      wait_pct = $urandom_range(0, 60);
      eo = ($urandom_range(3) == 0) ? $urandom_range(0, n - 1) : -1;
      run(sa, n, bs, eo, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stream_writer_ctrl.md
# wb_stream_writer_ctrl

Wishbone burst-read master that fetches a memory buffer and pushes it, word by word, into the stream writer FIFO's slave stream input. It sits directly upstream of the writer FIFO. It uses the FIFO occupancy count to start a burst only when the whole burst fits, so every acknowledged beat is accepted without back-pressure. A register/CSR block drives the configuration inputs and receives the status outputs.

## Interface
- WB_AW, 32, Wishbone address width (byte address)
- WB_DW, 32, Wishbone/stream data width; power of two, ≥ 8
- FIFO_AW, 0, must equal the downstream FIFO DEPTH_WIDTH; FIFO capacity = 2^FIFO_AW words
- MAX_BURST_W, 8, width of burst_size_i
---
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- wbm_adr_o  out  WB_AW  byte address of current beat
- wbm_sel_o  out  WB_DW/8  all ones while cyc high, else 0
- wbm_we_o  out  1  constant 0 (read only)
- wbm_cyc_o / wbm_stb_o  out  1  bus cycle / strobe (always equal)
- wbm_cti_o  out  3  010 incrementing, 111 on last beat of burst, 000 idle
- wbm_bte_o  out  2  constant 00 (linear)
- wbm_dat_i  in  WB_DW  read data
- wbm_ack_i / wbm_err_i  in  1  beat acknowledge / bus error
- fifo_data_o  out  WB_DW  data to FIFO stream_s_data_i
- fifo_valid_o  out  1  to FIFO stream_s_valid_i
- fifo_ready_i  in  1  from FIFO stream_s_ready_o
- fifo_cnt_i  in  FIFO_AW+1  FIFO occupancy count
- enable_i  in  1  start request (level)
- start_adr_i  in  WB_AW  buffer base byte address (word aligned)
- buf_size_i  in  WB_AW  buffer length in words
- burst_size_i  in  MAX_BURST_W  max words per burst; 0 treated as 1
- busy_o  out  1  high outside IDLE
- done_o  out  1  one-cycle pulse at buffer completion
- err_o  out  1  sticky bus error flag, cleared on next start

## Operation
- States: IDLE, WAIT_SPACE, BURST.
- IDLE: when enable_i=1, latch adr←start_adr_i, remaining←buf_size_i, bsize←max(burst_size_i,1), clear err_o, go to WAIT_SPACE. With buf_size_i=0, pulse done_o and stay in IDLE.
- WAIT_SPACE: blen = min(bsize, remaining). If remaining=0: pulse done_o, go to IDLE. Else if 2^FIFO_AW − fifo_cnt_i ≥ blen: load beat counter←blen, go to BURST. Otherwise wait. Compare at FIFO_AW+1 bits; remaining is saturated before comparing.
- BURST: cyc=stb=1, adr valid. cti=111 when beat counter=1, else 010.
  - On each ack: fifo_valid_o=1 and fifo_data_o=wbm_dat_i in the same cycle (combinational pass-through, no buffering); adr += WB_DW/8; remaining−1; beat counter−1.
  - After the last beat (counter 1→0): cyc/stb drop, go to WAIT_SPACE.
- fifo_valid_o is high only in ack cycles. Space reservation guarantees fifo_ready_i=1 then. fifo_ready_i is otherwise unused; a verification assertion checks that it is high whenever fifo_valid_o is high.
- wbm_err_i in BURST (with or without ack): the beat is not forwarded, cyc/stb drop next cycle, err_o←1, go to IDLE. No done_o pulse.
- enable_i deasserted mid-transfer: ignored; the buffer completes. A new start requires IDLE and enable_i=1. A level-held enable_i re-runs the buffer.
- Address wraps modulo 2^WB_AW.

## Timing
- Reset values: cyc/stb/we=0, cti=000, bte=00, sel=0, adr=0, fifo_valid_o=0, busy_o=0, done_o=0, err_o=0; state IDLE. Reset mid-burst: cyc drops on the reset edge; the partial buffer is discarded.
- IDLE→WAIT_SPACE takes 1 cycle. WAIT_SPACE→BURST takes 1 cycle once space suffices, so cyc is asserted 2 cycles after enable_i at the earliest.
- One beat per ack; zero-wait-state slaves give 1 word/cycle within a burst.
- At least 1 idle bus cycle separates bursts (WAIT_SPACE), which lets fifo_cnt_i absorb the last write.
- done_o pulses 1 cycle after the WAIT_SPACE cycle that sees remaining=0. busy_o falls in the same cycle.

## Test plan
- FIFO_AW=4, start=0x100, buf=8, burst=4, empty FIFO, 0-wait slave → two bursts at adr 0x100..0x10C and 0x110..0x11C; cti 010,010,010,111 in each; 8 FIFO writes in order; done_o pulses once.
- buf=10, burst=4 → bursts of 4, 4, 2; the final burst's cti=111 on its 2nd beat; final adr = 0x100+40.
- fifo_cnt_i held at 14 (FIFO_AW=4), burst=4 → controller waits in WAIT_SPACE with cyc=0; release to 12 → burst starts 1 cycle later.
- wbm_err_i on the 3rd beat of the 1st burst → 2 FIFO writes only; err_o=1; no done_o; returns to IDLE. A following start clears err_o.
- rst asserted mid-burst → next cycle all outputs at reset values; buf=0 start → done_o pulse with no bus cycle; random ack wait states → data order preserved and fifo_ready_i never low on fifo_valid_o.
